mem_wb_stage_pipe: RTL and testbench
====================================

# mem_wb_stage_pipe

Parametrised MEM→WB pipeline register with valid/ready flow control, flush, and an optional two-entry skid buffer. Sits between the data-memory stage and the write-back stage. It carries the ALU result, memory read value, destination register and control bits. It lets write-back stall without losing in-flight instructions, and it presents a pre-selected write-back datum to the register file.

## Interface
Parameters:
- DATA_W, 32, width of ALU result and memory read value
- REG_ADDR_W, 5, width of destination register index

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- wb_en_in  in  1  instruction writes a register
- mem_r_en_in  in  1  instruction is a load
- alu_result_in  in  DATA_W  ALU result
- mem_r_value_in  in  DATA_W  data-memory read value
- dest_in  in  REG_ADDR_W  destination register index
- out_valid  out  1  head entry valid
- out_ready  in  1  WB stage consumes head this cycle
- wb_en  out  1  head wb_en, forced 0 when out_valid=0
- mem_r_en  out  1  head mem_r_en, forced 0 when out_valid=0
- alu_result  out  DATA_W  head ALU result
- mem_r_value  out  DATA_W  head memory read value
- dest  out  REG_ADDR_W  head destination
- wb_data  out  DATA_W  mem_r_en ? mem_r_value : alu_result (combinational from head)

## Operation
- Entry = {wb_en, mem_r_en, alu_result, mem_r_value, dest}, with one valid bit per storage slot.
- accept = in_valid & in_ready. pop = out_valid & out_ready.
- Head register (main) drives all outputs. The skid register exists only with the macro.
- Occupancy states: EMPTY, ONE, FULL (FULL exists only with the macro).
  - EMPTY: accept → ONE.
  - ONE: accept & pop → ONE (main reloaded from input). accept & !pop → FULL (input into skid). pop & !accept → EMPTY.
  - FULL: pop → ONE (skid moves to main). in_ready=0, so no accept occurs in FULL.
- in_valid without in_ready: input is ignored; the producer must hold it.
- flush: next state EMPTY and both valid bits cleared; flush overrides an accept in the same cycle, and that input is discarded. Payload registers may hold stale data, but the gated outputs wb_en and mem_r_en read 0.
- Order is strictly FIFO; no entry is duplicated or dropped except by flush.

## Timing
- Reset: out_valid=0, wb_en=0, mem_r_en=0, alu_result=0, mem_r_value=0, dest=0, wb_data=0, state EMPTY, and in_ready=1 after reset deasserts.
- Latency: 1 cycle. An entry accepted at edge N gives out_valid=1 with its payload after edge N.
- Throughput: 1 entry/cycle when out_ready=1 continuously.
- With the macro, in_ready is a register output (in_ready = state≠FULL) and has no combinational path from out_ready.
- flush and rst take effect at the same edge / immediately respectively; rst mid-stream discards everything.

## Configuration
- MEM_WB_SKID_EN defined: two-entry skid buffer as above; in_ready is registered; up to 2 entries held.
- MEM_WB_SKID_EN undefined: single register only; in_ready = !out_valid | out_ready (combinational); FULL state and skid register absent. Throughput, latency, flush and reset behaviour are otherwise identical.

## Test plan
- Reset: assert rst mid-stream with out_valid=1 → all outputs 0 immediately; in_ready=1 after release.
- Streaming: out_ready=1, send dest=1..8 with alu_result=0x100+i on consecutive cycles → 8 outputs in order, each 1 cycle later, no bubbles.
- Backpressure (macro on): out_ready=0, offer 3 entries → first 2 accepted, in_ready=0 from the cycle after the second; release → outputs dest 1, 2, then 3, in order.
- Load select: mem_r_en_in=1, mem_r_value_in=0xDEADBEEF, alu_result_in=0x1000 → wb_data=0xDEADBEEF; with mem_r_en_in=0 → wb_data=0x1000.
- Flush with simultaneous accept while FULL → next cycle out_valid=0, wb_en=0, in_ready=1; the flushed entries never appear.
- Macro off: out_ready=0 with one entry held → in_ready=0; raise out_ready → in_ready=1 in the same cycle, and a new entry is accepted while the head pops.

Source files
------------

// File: rtl/mem_wb_stage_pipe_if.sv
// MEM->WB channel: upstream valid/ready plus payload, downstream valid/ready plus head fields.
// The stage uses the slave modport; the environment driving it uses master.
interface mem_wb_stage_pipe_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic                  wb_en_in;
  logic                  mem_r_en_in;
  logic [DATA_W-1:0]     alu_result_in;
  logic [DATA_W-1:0]     mem_r_value_in;
  logic [REG_ADDR_W-1:0] dest_in;
  logic                  out_valid;
  logic                  out_ready;
  logic                  wb_en;
  logic                  mem_r_en;
  logic [DATA_W-1:0]     alu_result;
  logic [DATA_W-1:0]     mem_r_value;
  logic [REG_ADDR_W-1:0] dest;
  logic [DATA_W-1:0]     wb_data;

  modport slave (
    input  flush, in_valid, wb_en_in, mem_r_en_in, alu_result_in, mem_r_value_in, dest_in,
           out_ready,
    output in_ready, out_valid, wb_en, mem_r_en, alu_result, mem_r_value, dest, wb_data
  );

  modport master (
    output flush, in_valid, wb_en_in, mem_r_en_in, alu_result_in, mem_r_value_in, dest_in,
           out_ready,
    input  in_ready, out_valid, wb_en, mem_r_en, alu_result, mem_r_value, dest, wb_data
  );
endinterface

// File: rtl/mem_wb_stage_pipe.sv
// MEM->WB pipeline register with valid/ready flow control and flush.
// Define MEM_WB_SKID_EN for a two-entry skid buffer with a registered in_ready.
module mem_wb_stage_pipe #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input logic                clk,
  input logic                rst,
  mem_wb_stage_pipe_if.slave bus
);

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     mem_r_value;
    logic [REG_ADDR_W-1:0] dest;
  } entry_t;

`ifdef MEM_WB_SKID_EN
  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;
`else
  typedef enum logic {StEmpty, StOne} state_e;
`endif

  state_e state_q;
  entry_t main_q;
  logic   main_valid_q;
  entry_t in_entry;
  logic   accept;
  logic   pop;

  assign in_entry = {bus.wb_en_in, bus.mem_r_en_in, bus.alu_result_in, bus.mem_r_value_in,
                     bus.dest_in};
  assign accept   = bus.in_valid & bus.in_ready;
  assign pop      = bus.out_valid & bus.out_ready;

`ifdef MEM_WB_SKID_EN
  entry_t skid_q;
  logic   skid_valid_q;
  logic   in_ready_q;

  assign bus.in_ready = in_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StEmpty;
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (bus.flush) begin
      // Payloads keep stale data; only the valid bits and state matter.
      state_q      <= StEmpty;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            main_q       <= in_entry;
            main_valid_q <= 1'b1;
            state_q      <= StOne;
          end
        end
        StOne: begin
          if (accept && pop) begin
            main_q <= in_entry;
          end else if (accept) begin
            skid_q       <= in_entry;
            skid_valid_q <= 1'b1;
            in_ready_q   <= 1'b0;
            state_q      <= StFull;
          end else if (pop) begin
            main_valid_q <= 1'b0;
            state_q      <= StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            main_q       <= skid_q;
            main_valid_q <= skid_valid_q;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            state_q      <= StOne;
          end
        end
        default: begin
          state_q      <= StEmpty;
          main_valid_q <= 1'b0;
          skid_valid_q <= 1'b0;
          in_ready_q   <= 1'b1;
        end
      endcase
    end
  end
`else
  // Single slot: can take a new entry whenever the head is empty or leaving.
  assign bus.in_ready = ~main_valid_q | bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StEmpty;
      main_q       <= '0;
      main_valid_q <= 1'b0;
    end else if (bus.flush) begin
      state_q      <= StEmpty;
      main_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            main_q       <= in_entry;
            main_valid_q <= 1'b1;
            state_q      <= StOne;
          end
        end
        StOne: begin
          if (accept) begin
            main_q <= in_entry;
          end else if (pop) begin
            main_valid_q <= 1'b0;
            state_q      <= StEmpty;
          end
        end
        default: begin
          state_q      <= StEmpty;
          main_valid_q <= 1'b0;
        end
      endcase
    end
  end
`endif

  assign bus.out_valid   = main_valid_q;
  assign bus.wb_en       = main_q.wb_en & main_valid_q;
  assign bus.mem_r_en    = main_q.mem_r_en & main_valid_q;
  assign bus.alu_result  = main_q.alu_result;
  assign bus.mem_r_value = main_q.mem_r_value;
  assign bus.dest        = main_q.dest;
  assign bus.wb_data     = main_q.mem_r_en ? main_q.mem_r_value : main_q.alu_result;

endmodule

// File: tb/tb_mem_wb_stage_pipe.sv
// Bench for mem_wb_stage_pipe: scoreboard of accepted entries, table of wb_data vectors,
// and hand-written reset, backpressure and flush sequences.
module tb_mem_wb_stage_pipe;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_stage_pipe_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();

  mem_wb_stage_pipe #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic          wb_en;
    logic          mem_r_en;
    logic [DW-1:0] alu;
    logic [DW-1:0] mv;
    logic [AW-1:0] dest;
  } ent_t;

  typedef struct {
    logic          mre;
    logic          wbe;
    logic [DW-1:0] alu;
    logic [DW-1:0] mv;
    logic [AW-1:0] dest;
    logic [DW-1:0] exp_wb;
  } vec_t;

  ent_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic wbe, input logic mre, input logic [DW-1:0] alu,
                       input logic [DW-1:0] mv, input logic [AW-1:0] d);
    bus.in_valid       = v;
    bus.wb_en_in       = wbe;
    bus.mem_r_en_in    = mre;
    bus.alu_result_in  = alu;
    bus.mem_r_value_in = mv;
    bus.dest_in        = d;
  endtask

  // Sample mid-cycle, update the scoreboard, then step past the next rising edge.
  task automatic cycle();
    ent_t e;
    @(negedge clk);
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("pop_unexpected", {27'd0, bus.dest}, 32'hffff_ffff);
        end else begin
          e = sb.pop_front();
          chk("pop_dest", {27'd0, bus.dest}, {27'd0, e.dest});
          chk("pop_alu", bus.alu_result, e.alu);
          chk("pop_mem_r_value", bus.mem_r_value, e.mv);
          chk("pop_wb_en", {31'd0, bus.wb_en}, {31'd0, e.wb_en});
          chk("pop_mem_r_en", {31'd0, bus.mem_r_en}, {31'd0, e.mem_r_en});
          chk("pop_wb_data", bus.wb_data, e.mem_r_en ? e.mv : e.alu);
        end
      end else if (!bus.out_valid) begin
        chk("gated_ctrl", {30'd0, bus.wb_en, bus.mem_r_en}, 32'd0);
      end
      if (bus.flush) begin
        sb.delete();
      end else if (bus.in_valid && bus.in_ready) begin
        sb.push_back({bus.wb_en_in, bus.mem_r_en_in, bus.alu_result_in, bus.mem_r_value_in,
                      bus.dest_in});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0 && !bus.out_valid) break;
      cycle();
    end
    chk("drain_empty", sb.size(), 32'd0);
    chk("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);
  endtask

  vec_t vt[4];

  initial begin
    vt[0] = '{mre: 1'b1, wbe: 1'b1, alu: 32'h0000_1000, mv: 32'hDEAD_BEEF, dest: 5'd3,
              exp_wb: 32'hDEAD_BEEF};
    vt[1] = '{mre: 1'b0, wbe: 1'b1, alu: 32'h0000_1000, mv: 32'hDEAD_BEEF, dest: 5'd4,
              exp_wb: 32'h0000_1000};
    vt[2] = '{mre: 1'b1, wbe: 1'b0, alu: 32'h1234_5678, mv: 32'h0000_0000, dest: 5'd31,
              exp_wb: 32'h0000_0000};
    vt[3] = '{mre: 1'b0, wbe: 1'b0, alu: 32'hFFFF_FFFF, mv: 32'h5555_AAAA, dest: 5'd0,
              exp_wb: 32'hFFFF_FFFF};

    rst       = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_wb_data", bus.wb_data, 32'd0);
    chk("reset_dest", {27'd0, bus.dest}, 32'd0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Streaming at full throughput, no bubbles.
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h100 + i, 32'h0, i[AW-1:0]);
      if (i > 1) chk("stream_no_bubble", {31'd0, bus.out_valid}, 32'd1);
      cycle();
    end
    drain();

    // wb_data select table.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vt[i].wbe, vt[i].mre, vt[i].alu, vt[i].mv, vt[i].dest);
      cycle();
      chk("vec_wb_data", bus.wb_data, vt[i].exp_wb);
      chk("vec_wb_en", {31'd0, bus.wb_en}, {31'd0, vt[i].wbe});
      chk("vec_mem_r_en", {31'd0, bus.mem_r_en}, {31'd0, vt[i].mre});
    end
    drain();

    // Asynchronous reset mid-stream.
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'hAAAA_0001, 32'hBBBB_0001, 5'd7);
    cycle();
    bus.in_valid = 1'b0;
    chk("pre_reset_out_valid", {31'd0, bus.out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_ctrl", {30'd0, bus.wb_en, bus.mem_r_en}, 32'd0);
    chk("rst_alu", bus.alu_result, 32'd0);
    chk("rst_mem_r_value", bus.mem_r_value, 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_dest", {27'd0, bus.dest}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_release_in_ready", {31'd0, bus.in_ready}, 32'd1);

`ifdef MEM_WB_SKID_EN
    // Backpressure: two entries held, third must wait.
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h201, 32'h0, 5'd1);
    cycle();
    chk("bp_in_ready_one", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h202, 32'h0, 5'd2);
    cycle();
    chk("bp_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h203, 32'h0, 5'd3);
    repeat (2) cycle();
    chk("bp_in_ready_hold", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_head_dest", {27'd0, bus.dest}, 32'd1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (bus.in_ready) begin
        cycle();
        bus.in_valid = 1'b0;
        break;
      end
      cycle();
    end
    chk("bp_third_accepted", {31'd0, bus.in_valid}, 32'd0);
    drain();

    // Flush while FULL with a pending offer; nothing flushed may reappear.
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'h301, 32'h401, 5'd11);
    cycle();
    drive(1'b1, 1'b1, 1'b1, 32'h302, 32'h402, 5'd12);
    cycle();
    drive(1'b1, 1'b1, 1'b1, 32'h303, 32'h403, 5'd13);
    bus.flush = 1'b1;
    cycle();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_full_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_full_ctrl", {30'd0, bus.wb_en, bus.mem_r_en}, 32'd0);
    chk("flush_full_in_ready", {31'd0, bus.in_ready}, 32'd1);
    drain();
`else
    // Single slot: in_ready follows out_ready combinationally.
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h501, 32'h0, 5'd21);
    cycle();
    bus.in_valid = 1'b0;
    #1;
    chk("single_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    #1;
    chk("single_in_ready_comb", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h502, 32'h0, 5'd22);
    cycle();
    bus.in_valid = 1'b0;
    chk("single_replace_dest", {27'd0, bus.dest}, 32'd22);
    drain();
`endif

    // Flush with a simultaneous accept from one held entry.
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h601, 32'h0, 5'd25);
    cycle();
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'h602, 32'h702, 5'd26);
    bus.flush = 1'b1;
    cycle();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_accept_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_accept_ctrl", {30'd0, bus.wb_en, bus.mem_r_en}, 32'd0);
    chk("flush_accept_in_ready", {31'd0, bus.in_ready}, 32'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
